fir_cfg_regfile: RTL

- Config register bank and tap-coefficient BRAM front end for the FIR block.
- Sits directly downstream of the AXI4-Lite read and write channel FSMs. It consumes their captured address and write data, and returns read data.
- Holds ap_ctrl and data_length, and arbitrates the tap BRAM port between the AXI config path and the FIR engine.

---
 rtl/fir_cfg_regfile.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fir_cfg_regfile.sv
// fir_cfg_regfile: FIR config register bank (ap_ctrl, data_length) and tap BRAM port arbiter.
// Define FIR_CFG_IRQ_EN to add the irq_en register at 0x04 and the registered irq output.
module fir_cfg_regfile #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pTAP_BASE   = 32'h020,
  parameter int unsigned pTAP_LAST   = 32'h0FF
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   wr_en,
  input  logic [pADDR_WIDTH-1:0] wr_addr,
  input  logic [pDATA_WIDTH-1:0] wr_data,
  input  logic                   rd_req,
  input  logic [pADDR_WIDTH-1:0] rd_addr,
  output logic [pDATA_WIDTH-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ack,
  output logic                   rd_busy,
  output logic                   ap_start,
  input  logic                   engine_done,
  output logic [31:0]            data_length,
`ifdef FIR_CFG_IRQ_EN
  output logic                   irq,
`endif
  input  logic                   eng_tap_EN,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic                   tap_EN,
  output logic [3:0]             tap_WE,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h00);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(pTAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(pTAP_LAST);
`ifdef FIR_CFG_IRQ_EN
  localparam logic [pADDR_WIDTH-1:0] ADDR_IRQEN = pADDR_WIDTH'(32'h04);
`endif

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_CAPT, R_HOLD} rd_state_e;

  rd_state_e              state_q, state_d;
  logic [pADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [pDATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_busy_q, rd_busy_d;
  logic                   rd_tap_ok_q, rd_tap_ok_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_idle_q, ap_idle_d;
  logic                   ap_done_q, ap_done_d;
  logic [31:0]            data_length_q, data_length_d;
`ifdef FIR_CFG_IRQ_EN
  logic                   irq_en_q, irq_en_d;
  logic                   irq_q, irq_d;
`endif

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_BASE) && (a <= TAP_LAST);
  endfunction

  logic rd_is_tap;
  logic wr_tap;
  assign rd_is_tap = is_tap(rd_addr_q);
  assign wr_tap    = wr_en && ap_idle_q && is_tap(wr_addr);

  // Register writes, engine handshake and the read FSM
  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = rd_valid_q;
    rd_busy_d     = rd_busy_q;
    rd_tap_ok_d   = rd_tap_ok_q;
    ap_start_d    = 1'b0;
    ap_idle_d     = ap_idle_q;
    ap_done_d     = ap_done_q;
    data_length_d = data_length_q;
`ifdef FIR_CFG_IRQ_EN
    irq_en_d      = irq_en_q;
    irq_d         = ap_done_q & irq_en_q;
    if (wr_en && (wr_addr == ADDR_IRQEN)) irq_en_d = wr_data[0];
`endif

    if (wr_en && ap_idle_q) begin
      if ((wr_addr == ADDR_CTRL) && wr_data[0]) begin
        ap_start_d = 1'b1;
        ap_idle_d  = 1'b0;
        ap_done_d  = 1'b0;
      end
      if (wr_addr == ADDR_LEN) data_length_d = 32'(wr_data);
    end

    case (state_q)
      R_IDLE: begin
        if (rd_req) begin
          rd_addr_d = rd_addr;
          rd_busy_d = 1'b1;
          state_d   = R_ISSUE;
        end
      end
      R_ISSUE: begin
        // A concurrent tap write owns the BRAM port; retry the read next cycle
        if (!(rd_is_tap && wr_tap)) begin
          rd_tap_ok_d = ap_idle_q;
          state_d     = R_CAPT;
        end
      end
      R_CAPT: begin
        rd_valid_d = 1'b1;
        state_d    = R_HOLD;
        if (rd_is_tap) begin
          rd_data_d = rd_tap_ok_q ? tap_Do : '1;
        end else if (rd_addr_q == ADDR_CTRL) begin
          rd_data_d = pDATA_WIDTH'({ap_idle_q, ap_done_q, 1'b0});
          ap_done_d = 1'b0;
        end else if (rd_addr_q == ADDR_LEN) begin
          rd_data_d = pDATA_WIDTH'(data_length_q);
`ifdef FIR_CFG_IRQ_EN
        end else if (rd_addr_q == ADDR_IRQEN) begin
          rd_data_d = pDATA_WIDTH'(irq_en_q);
`endif
        end else begin
          rd_data_d = '0;
        end
      end
      R_HOLD: begin
        if (rd_ack) begin
          rd_valid_d = 1'b0;
          rd_busy_d  = 1'b0;
          state_d    = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase

    // Completion overrides a same-cycle read-clear of ap_done
    if (engine_done) begin
      ap_done_d = 1'b1;
      ap_idle_d = 1'b1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q       <= R_IDLE;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_busy_q     <= 1'b0;
      rd_tap_ok_q   <= 1'b0;
      ap_start_q    <= 1'b0;
      ap_idle_q     <= 1'b1;
      ap_done_q     <= 1'b0;
      data_length_q <= '0;
`ifdef FIR_CFG_IRQ_EN
      irq_en_q      <= 1'b0;
      irq_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_busy_q     <= rd_busy_d;
      rd_tap_ok_q   <= rd_tap_ok_d;
      ap_start_q    <= ap_start_d;
      ap_idle_q     <= ap_idle_d;
      ap_done_q     <= ap_done_d;
      data_length_q <= data_length_d;
`ifdef FIR_CFG_IRQ_EN
      irq_en_q      <= irq_en_d;
      irq_q         <= irq_d;
`endif
    end
  end

  // Tap BRAM port: engine while running, otherwise config write beats config read
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (!ap_idle_q) begin
      tap_EN = eng_tap_EN;
      tap_A  = eng_tap_A;
    end else if (wr_tap) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = wr_addr - TAP_BASE;
      tap_Di = wr_data;
    end else if ((state_q == R_ISSUE) && rd_is_tap) begin
      tap_EN = 1'b1;
      tap_A  = rd_addr_q - TAP_BASE;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_busy     = rd_busy_q;
  assign ap_start    = ap_start_q;
  assign data_length = data_length_q;
`ifdef FIR_CFG_IRQ_EN
  assign irq         = irq_q;
`endif

endmodule
